mem_dma_master: RTL and testbench

//  Word-copy DMA engine acting as an initiator on the native picorv32 memory bus (valid/ready).

---
 rtl/mem_dma_pkg.sv | 25 ++
 rtl/mem_dma_if.sv | 20 ++
 rtl/mem_dma_timeout.sv | 36 +++
 rtl/mem_dma_master.sv | 186 ++++++++++++++++++
 tb/tb_mem_dma_master.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_dma_pkg.sv
// Shared types and constants for the mem_dma_master word-copy engine.
package mem_dma_pkg;

  // Copy engine states: one bus transaction per RD/WR, each followed by a
  // single idle cycle so responders see mem_valid drop between requests.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    RD_GAP = 3'd2,
    WR     = 3'd3,
    WR_GAP = 3'd4,
    FIN    = 3'd5,
    ERR    = 3'd6
  } state_t;

  localparam logic [3:0]  WSTRB_FULL = 4'hF;
  localparam logic [3:0]  WSTRB_NONE = 4'h0;
  localparam logic [31:0] WORD_BYTES = 32'd4;

  // Force a byte address onto a 32-bit word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/mem_dma_if.sv
// Native picorv32 memory bus (valid/ready) as seen by one initiator.
interface mem_dma_if;
  logic        mem_valid;
  logic        mem_instr;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_dma_timeout.sv
// Per-transaction watchdog for mem_dma_master. Only built when
// MEM_DMA_TIMEOUT_EN is defined; the counter is held clear by 'load' outside
// bus transactions and 'expired' flags the last allowed waiting cycle.
`ifdef MEM_DMA_TIMEOUT_EN
module mem_dma_timeout #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic run,
  output logic expired
);

  localparam int            CW   = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_r;

  // Count cycles spent waiting for mem_ready, saturating at the last one.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {CW{1'b0}};
    end else if (load) begin
      cnt_r <= {CW{1'b0}};
    end else if (run && (cnt_r != LAST)) begin
      cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired = run && (cnt_r == LAST);

endmodule
`endif

// File: rtl/mem_dma_master.sv
// mem_dma_master: word-copy DMA initiator on the picorv32 valid/ready bus.
// Reads word_count words from src_addr and writes them to dst_addr, one
// transaction at a time with a mandatory idle cycle after every transaction.
// Optional feature macro: MEM_DMA_TIMEOUT_EN (abort on a stalled responder).
module mem_dma_master
  import mem_dma_pkg::*;
#(
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [CNT_W-1:0] word_count,
  output logic             busy,
  output logic             done,
  output logic             error,
  mem_dma_if.master        bus
);

  state_t           state_r, state_s;
  logic [31:0]      src_r, src_s;
  logic [31:0]      dst_r, dst_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [31:0]      addr_r, addr_s;
  logic [31:0]      wdata_r, wdata_s;
  logic [3:0]       wstrb_r, wstrb_s;
  logic             valid_r, valid_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             timeout_s;

`ifdef MEM_DMA_TIMEOUT_EN
  logic active_s;
  logic error_r;

  assign active_s = (state_r == RD) || (state_r == WR);

  mem_dma_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .load    (!active_s),
    .run     (active_s),
    .expired (timeout_s)
  );

  // Error pulse is registered alongside the other outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      error_r <= 1'b0;
    end else begin
      error_r <= (state_s == ERR);
    end
  end

  assign error = error_r;
`else
  logic [31:0] unused_timeout;

  assign unused_timeout = 32'(TIMEOUT_CYCLES);
  assign timeout_s      = 1'b0;
  assign error          = 1'b0;
`endif

  // Next-state, datapath updates and next registered bus outputs.
  always_comb begin
    state_s = state_r;
    src_s   = src_r;
    dst_s   = dst_r;
    cnt_s   = cnt_r;
    addr_s  = addr_r;
    wdata_s = wdata_r;

    case (state_r)
      IDLE: begin
        if (start) begin
          if (word_count != {CNT_W{1'b0}}) begin
            state_s = RD;
            src_s   = word_align(src_addr);
            dst_s   = word_align(dst_addr);
            cnt_s   = word_count;
          end else begin
            state_s = FIN;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RD: begin
        if (bus.mem_ready) begin
          wdata_s = bus.mem_rdata;
          src_s   = src_r + WORD_BYTES;
          state_s = RD_GAP;
        end else if (timeout_s) begin
          state_s = ERR;
        end else begin
          state_s = RD;
        end
      end
      RD_GAP: begin
        state_s = WR;
      end
      WR: begin
        if (bus.mem_ready) begin
          dst_s   = dst_r + WORD_BYTES;
          cnt_s   = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          state_s = WR_GAP;
        end else if (timeout_s) begin
          state_s = ERR;
        end else begin
          state_s = WR;
        end
      end
      WR_GAP: begin
        if (cnt_r != {CNT_W{1'b0}}) begin
          state_s = RD;
        end else begin
          state_s = FIN;
        end
      end
      FIN: begin
        state_s = IDLE;
      end
      ERR: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    // Address only moves when a new transaction is presented, so it stays
    // stable for the whole time mem_valid waits on mem_ready.
    case (state_s)
      RD:      addr_s = src_s;
      WR:      addr_s = dst_s;
      default: addr_s = addr_r;
    endcase

    valid_s = (state_s == RD) || (state_s == WR);
    wstrb_s = (state_s == WR) ? WSTRB_FULL : WSTRB_NONE;
    busy_s  = (state_s == RD) || (state_s == RD_GAP) ||
              (state_s == WR) || (state_s == WR_GAP);
    done_s  = (state_s == FIN);
  end

  // State, datapath and registered outputs; reset clears everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      src_r   <= 32'h0000_0000;
      dst_r   <= 32'h0000_0000;
      cnt_r   <= {CNT_W{1'b0}};
      addr_r  <= 32'h0000_0000;
      wdata_r <= 32'h0000_0000;
      wstrb_r <= WSTRB_NONE;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      src_r   <= src_s;
      dst_r   <= dst_s;
      cnt_r   <= cnt_s;
      addr_r  <= addr_s;
      wdata_r <= wdata_s;
      wstrb_r <= wstrb_s;
      valid_r <= valid_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign busy          = busy_r;
  assign done          = done_r;
  assign bus.mem_valid = valid_r;
  assign bus.mem_instr = 1'b0;
  assign bus.mem_addr  = addr_r;
  assign bus.mem_wdata = wdata_r;
  assign bus.mem_wstrb = wstrb_r;

endmodule

// File: tb/tb_mem_dma_master.sv
// Bench for mem_dma_master: 16 kB memory responder with fixed or random wait
// states, bus monitor, and a transfer-level reference model (expected list of
// read/write transactions and expected destination contents).
module tb_mem_dma_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] src_addr = 32'h0;
  logic [31:0] dst_addr = 32'h0;
  logic [15:0] word_count = 16'h0;
  logic        busy, done, error;

  mem_dma_if bus();

  mem_dma_master #(.CNT_W(16), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .start(start), .src_addr(src_addr),
    .dst_addr(dst_addr), .word_count(word_count), .busy(busy),
    .done(done), .error(error), .bus(bus)
  );

  always #5 clk = ~clk;

  // ---------------- responder ----------------
  logic [31:0] mem [0:4095];
  int wait_cnt = 0, cur_wait = 0, fixed_wait = 0;
  bit rand_wait = 1'b0, never_ready = 1'b0;

  always_comb begin
    bus.mem_ready = bus.mem_valid && !never_ready && (wait_cnt >= cur_wait);
    bus.mem_rdata = mem[bus.mem_addr[13:2]];
  end

  always @(posedge clk) begin
    if (bus.mem_valid && bus.mem_ready && bus.mem_wstrb == 4'hF)
      mem[bus.mem_addr[13:2]] <= bus.mem_wdata;
    if (!bus.mem_valid || bus.mem_ready) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
    if (!bus.mem_valid) cur_wait <= rand_wait ? int'($urandom_range(0, 3)) : fixed_wait;
  end

  // ---------------- monitor ----------------
  typedef struct { logic [3:0] wstrb; logic [31:0] addr; logic [31:0] data; } op_t;
  op_t ops[$];
  int busy_n = 0, valid_n = 0, done_n = 0, err_n = 0, stab_viol = 0, gap_viol = 0;
  bit prev_stall = 1'b0, prev_acc = 1'b0;
  logic [31:0] p_addr, p_wdata;
  logic [3:0]  p_wstrb;

  always begin
    @(posedge clk); #1;
    if (reset) begin
      prev_stall = 1'b0;
      prev_acc = 1'b0;
    end else begin
      if (prev_stall && !error && (bus.mem_valid !== 1'b1 || bus.mem_addr !== p_addr ||
          bus.mem_wdata !== p_wdata || bus.mem_wstrb !== p_wstrb)) stab_viol++;
      if (prev_acc && bus.mem_valid !== 1'b0) gap_viol++;
      if (bus.mem_valid && bus.mem_ready)
        ops.push_back('{bus.mem_wstrb, bus.mem_addr,
                        (bus.mem_wstrb == 4'hF) ? bus.mem_wdata : bus.mem_rdata});
      prev_stall = bus.mem_valid && !bus.mem_ready;
      prev_acc   = bus.mem_valid && bus.mem_ready;
      p_addr = bus.mem_addr; p_wdata = bus.mem_wdata; p_wstrb = bus.mem_wstrb;
    end
    if (busy) busy_n++;
    if (bus.mem_valid) valid_n++;
    if (done) done_n++;
    if (error) err_n++;
  end

  // ---------------- checking ----------------
  int n_vec = 0, n_miss = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // One copy through the DUT; the model is the list of words written to the
  // source, from which the expected transactions and destination follow.
  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] c,
                          input int fw, input bit rnd, input int restart,
                          output int lat, output int ops_bad, output int mem_bad);
    logic [31:0] sa, da, a, v;
    logic [31:0] data_q[$];
    sa = s & 32'hFFFF_FFFC;
    da = d & 32'hFFFF_FFFC;
    @(negedge clk);
    fixed_wait = fw;
    rand_wait = rnd;
    for (int i = 0; i < int'(c); i++) begin
      v = $urandom;
      data_q.push_back(v);
      a = sa + 32'(4 * i);
      mem[a[13:2]] <= v;
    end
    @(negedge clk);
    ops.delete();
    busy_n = 0; valid_n = 0; done_n = 0; err_n = 0;
    start = 1'b1; src_addr = s; dst_addr = d; word_count = c;
    lat = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      lat++;
      if (k == restart) begin
        start = 1'b1; src_addr = 32'h0000_3000; dst_addr = 32'h0000_3800; word_count = 16'd9;
      end else begin
        start = 1'b0;
      end
      if (done_n > 0 || err_n > 0) break;
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    ops_bad = 0;
    if (ops.size() != 2 * int'(c)) begin
      ops_bad = 9999;
    end else begin
      for (int i = 0; i < int'(c); i++) begin
        a = sa + 32'(4 * i);
        if (ops[2*i].wstrb !== 4'h0 || ops[2*i].addr !== a || ops[2*i].data !== data_q[i]) ops_bad++;
        a = da + 32'(4 * i);
        if (ops[2*i+1].wstrb !== 4'hF || ops[2*i+1].addr !== a || ops[2*i+1].data !== data_q[i]) ops_bad++;
      end
    end
    mem_bad = 0;
    for (int i = 0; i < int'(c); i++) begin
      a = da + 32'(4 * i);
      if (mem[a[13:2]] !== data_q[i]) mem_bad++;
    end
  endtask

  typedef struct {
    logic [31:0] src; logic [31:0] dst; logic [15:0] cnt; int waits;
    int exp_busy; int exp_valid; int exp_lat;
  } vec_t;
  vec_t tbl[5];

  initial begin
    int lat, ob, mb, found;
    logic [31:0] s, d;
    logic [15:0] c;

    // busy = cnt*(2*waits+4) cycles, valid = cnt*2*(waits+1), done one cycle later
    tbl[0] = '{32'h0000_0100, 32'h0000_0200, 16'd4, 0, 16, 8, 17};
    tbl[1] = '{32'h0000_1000, 32'h0000_2000, 16'd0, 0, 0, 0, 1};
    tbl[2] = '{32'hFFFF_FFFC, 32'h0000_0400, 16'd2, 0, 8, 4, 9};
    tbl[3] = '{32'h0000_0503, 32'h0000_0602, 16'd3, 2, 24, 18, 25};
    tbl[4] = '{32'h0000_0800, 32'h0000_0900, 16'd1, 1, 6, 4, 7};

    for (int i = 0; i < 4096; i++) mem[i] <= 32'h0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {busy, done, error, bus.mem_valid, bus.mem_instr, bus.mem_wstrb}, 64'h0);
    chk("rst_addr", bus.mem_addr, 64'h0);
    chk("rst_wdata", bus.mem_wdata, 64'h0);
    reset = 1'b0;

    for (int t = 0; t < 5; t++) begin
      run_copy(tbl[t].src, tbl[t].dst, tbl[t].cnt, tbl[t].waits, 1'b0, -1, lat, ob, mb);
      chk($sformatf("v%0d_busy", t), busy_n, tbl[t].exp_busy);
      chk($sformatf("v%0d_valid", t), valid_n, tbl[t].exp_valid);
      chk($sformatf("v%0d_done_lat", t), lat, tbl[t].exp_lat);
      chk($sformatf("v%0d_done_cnt", t), done_n, 1);
      chk($sformatf("v%0d_ops", t), ob, 0);
      chk($sformatf("v%0d_mem", t), mb, 0);
    end

    for (int r = 0; r < 6; r++) begin
      s = $urandom; s[13:12] = 2'b00;
      d = $urandom; d[13:12] = 2'b10;
      c = 16'($urandom_range(1, 8));
      run_copy(s, d, c, 0, 1'b1, -1, lat, ob, mb);
      chk($sformatf("r%0d_ops", r), ob, 0);
      chk($sformatf("r%0d_mem", r), mb, 0);
      chk($sformatf("r%0d_done_cnt", r), done_n, 1);
      chk($sformatf("r%0d_busy_span", r), busy_n, lat - 1);
    end

    // second start during a copy must be ignored
    run_copy(32'h0000_0140, 32'h0000_0240, 16'd6, 0, 1'b0, 3, lat, ob, mb);
    chk("restart_done_cnt", done_n, 1);
    chk("restart_ops", ob, 0);
    chk("restart_mem", mb, 0);
    chk("restart_busy", busy_n, 24);
    chk("restart_lat", lat, 25);

    // reset while a write is waiting on mem_ready
    fixed_wait = 1; rand_wait = 1'b0;
    @(negedge clk);
    start = 1'b1; src_addr = 32'h0000_0100; dst_addr = 32'h0000_0200; word_count = 16'd8;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int k = 0; k < 100; k++) begin
      if (bus.mem_valid && bus.mem_wstrb == 4'hF) begin found = 1; break; end
      @(negedge clk);
    end
    chk("reach_wr", found, 1);
    reset = 1'b1;
    done_n = 0;
    @(negedge clk);
    chk("wrrst_ctrl", {busy, done, error, bus.mem_valid, bus.mem_instr, bus.mem_wstrb}, 64'h0);
    chk("wrrst_addr", bus.mem_addr, 64'h0);
    chk("wrrst_wdata", bus.mem_wdata, 64'h0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("wrrst_no_done", done_n, 0);
    chk("wrrst_idle", {busy, bus.mem_valid}, 64'h0);
    run_copy(32'h0000_0180, 32'h0000_0280, 16'd3, 2, 1'b0, -1, lat, ob, mb);
    chk("after_rst_done_cnt", done_n, 1);
    chk("after_rst_ops", ob, 0);
    chk("after_rst_mem", mb, 0);
    chk("after_rst_busy", busy_n, 24);

`ifdef MEM_DMA_TIMEOUT_EN
    // responder never answers: abort after 8 waiting cycles
    never_ready = 1'b1;
    @(negedge clk);
    busy_n = 0; valid_n = 0; done_n = 0; err_n = 0;
    start = 1'b1; src_addr = 32'h0000_0100; dst_addr = 32'h0000_0200; word_count = 16'd2;
    lat = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      lat++;
      start = 1'b0;
      if (err_n > 0) break;
    end
    chk("to_err_lat", lat, 9);
    chk("to_valid_cycles", valid_n, 8);
    chk("to_outs", {error, bus.mem_valid, busy}, 64'h4);
    never_ready = 1'b0;
    repeat (5) @(negedge clk);
    chk("to_err_cnt", err_n, 1);
    chk("to_no_done", done_n, 0);
`endif

    chk("stable_while_wait", stab_viol, 0);
    chk("gap_after_ready", gap_viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
